// File: rtl/prim_reqack_arb_pkg.sv
// Shared types and helpers for the round-robin REQ/ACK arbiter.
//
// Contents:
//   arb_state_e : two-state arbiter FSM encoding (idle / grant outstanding)
//   idx_width() : width of a requester index for N requesters (never below 1)
package prim_reqack_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  // A single requester still needs a one-bit index so ports never collapse
  // to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prim_rr_sel.sv
// Purely combinational round-robin selector.
//
// Picks the first set request bit at or after the pointer, searching upward
// and wrapping from N-1 back to 0.
//
// Ports:
//   req   in  N     request vector
//   ptr   in  IdxW  search start position (must be < N)
//   valid out 1     at least one request is set
//   idx   out IdxW  winning requester index (0 when valid is low)
module prim_rr_sel
  import prim_reqack_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic            valid,
  output logic [IdxW-1:0] idx
);

  localparam logic [IdxW:0] NVal = (IdxW + 1)'(N);

  logic [N-1:0]  rot;
  logic [IdxW:0] sum;

  // Rotating a doubled copy puts requester (ptr+k) mod N at bit k, so the
  // lowest set bit of rot is the round-robin winner. The index is rebuilt
  // with an explicit subtract-N wrap so non-power-of-two N works.
  always_comb begin
    rot   = N'({req, req} >> ptr);
    valid = 1'b0;
    sum   = '0;
    for (int k = 0; k < N; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        sum   = {1'b0, ptr} + (IdxW + 1)'(k);
      end
    end
    if (sum >= NVal) begin
      sum = sum - NVal;
    end
    idx = sum[IdxW-1:0];
  end

endmodule

// File: rtl/prim_reqack_arb.sv
// Round-robin arbiter sharing one REQ/ACK channel (typically the source side
// of a REQ/ACK CDC synchronizer) between N requesters, with a grant watchdog.
//
// Ports:
//   clk_i         in  1     clock
//   rst_i         in  1     synchronous active-high reset
//   req_i         in  N     per-requester level REQ, held until its ack_o
//   ack_o         out N     per-requester one-cycle ACK, at most one bit set
//   gnt_idx_o     out IdxW  current / last granted requester (data mux steer)
//   busy_o        out 1     grant outstanding
//   out_req_o     out 1     shared REQ toward the synchronizer
//   out_ack_i     in  1     shared one-cycle ACK from the synchronizer
//   timeout_o     out 1     sticky watchdog flag
//   timeout_clr_i in  1     clears timeout_o (a coincident set wins)
module prim_reqack_arb
  import prim_reqack_arb_pkg::*;
#(
  parameter  int N             = 4,
  parameter  int TimeoutCycles = 1024,
  localparam int IdxW          = idx_width(N),
  localparam int CntW          = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    ack_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            busy_o,
  output logic            out_req_o,
  input  logic            out_ack_i,
  output logic            timeout_o,
  input  logic            timeout_clr_i
);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            sel_valid;
  logic [IdxW-1:0] sel_idx;
  logic            granted;
  logic            timeout_q;

  prim_rr_sel #(
    .N    (N),
    .IdxW (IdxW)
  ) u_sel (
    .req   (req_i),
    .ptr   (ptr_q),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Arbitrate only in IDLE; once granted, the index is frozen and other
  // requesters are ignored until the shared ACK returns. The pointer moves
  // just past the served requester, giving it lowest priority next time.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (sel_valid) begin
          state_d = ARB_GRANT;
          gnt_d   = sel_idx;
        end
      end
      ARB_GRANT: begin
        if (out_ack_i) begin
          state_d = ARB_IDLE;
          ptr_d   = (gnt_q == IdxW'(N - 1)) ? '0 : gnt_q + IdxW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign granted   = (state_q == ARB_GRANT);
  assign out_req_o = granted;
  assign busy_o    = granted;
  assign gnt_idx_o = gnt_q;
  assign timeout_o = timeout_q;

  // The ACK is routed straight through in the same cycle; a reset cycle
  // discards the grant without acknowledging it.
  always_comb begin
    ack_o = '0;
    if (granted && out_ack_i && !rst_i) begin
      ack_o[gnt_q] = 1'b1;
    end
  end

  if (TimeoutCycles > 0) begin : g_wdog
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

    logic [CntW-1:0] cnt_q;

    // Counts GRANT cycles without ACK, saturating so the flag keeps being
    // re-armed while the grant stays stuck.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else if (!granted && state_d == ARB_GRANT) begin
        cnt_q <= '0;
      end else if (granted && !out_ack_i && cnt_q != CntMax) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end

    // Set has priority over clear so a still-stuck grant cannot be masked.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        timeout_q <= 1'b0;
      end else if (granted && cnt_q == CntMax) begin
        timeout_q <= 1'b1;
      end else if (timeout_clr_i) begin
        timeout_q <= 1'b0;
      end
    end
  end else begin : g_no_wdog
    assign timeout_q = 1'b0;
  end

  a_ack_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(ack_o));

  a_req_held : assert property (@(posedge clk_i) disable iff (rst_i)
    ($past(out_req_o) && !$past(out_ack_i) && !$past(rst_i)) |-> out_req_o);

  a_ack_needs_req : assert property (@(posedge clk_i) disable iff (rst_i)
    out_ack_i |-> out_req_o);

  a_gnt_req_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    busy_o |-> req_i[gnt_idx_o]);

endmodule

// File: tb/tb_prim_reqack_arb.sv
// Self-checking bench for prim_reqack_arb (N=4, TimeoutCycles=8).
// Stimulus is applied just after each rising edge; a reference model predicts
// per-cycle outputs and ACK vectors, and a monitor checks them at the falling edge.
module tb_prim_reqack_arb;

  localparam int N    = 4;
  localparam int TO   = 8;
  localparam int IdxW = 2;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_i;
  logic [N-1:0]    ack_o;
  logic [IdxW-1:0] gnt_idx_o;
  logic            busy_o;
  logic            out_req_o;
  logic            out_ack_i;
  logic            timeout_o;
  logic            timeout_clr_i;

  typedef struct {
    logic            req;
    logic            to;
    logic [IdxW-1:0] gnt;
  } cyc_exp_t;

  cyc_exp_t     cyc_q[$];
  logic [N-1:0] ack_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model: a grant is either outstanding or not, the pointer names
  // the highest-priority requester, and elapsed counts unacknowledged grant cycles.
  bit m_valid   = 1'b0;
  bit m_busy    = 1'b0;
  int m_gnt     = 0;
  int m_ptr     = 0;
  int m_elapsed = 0;
  bit m_to      = 1'b0;

  // 10-unit clock period.
  always #5 clk = ~clk;

  prim_reqack_arb #(
    .N             (N),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .ack_o         (ack_o),
    .gnt_idx_o     (gnt_idx_o),
    .busy_o        (busy_o),
    .out_req_o     (out_req_o),
    .out_ack_i     (out_ack_i),
    .timeout_o     (timeout_o),
    .timeout_clr_i (timeout_clr_i)
  );

  function automatic bit bitOf(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  // First requester at or after p, walking upward modulo N; -1 when none.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (bitOf(r, (p + k) % N)) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, queues the outputs the model expects during
  // that cycle, then advances the model across the next edge.
  task automatic applyStimulus(input logic [N-1:0] req, input logic ack,
                               input logic clr, input logic rst);
    cyc_exp_t e;
    int       w;
    @(posedge clk);
    #1;
    if (m_valid) begin
      e.req = m_busy;
      e.to  = m_to;
      e.gnt = IdxW'(m_gnt);
      cyc_q.push_back(e);
    end
    req_i         = req;
    out_ack_i     = ack;
    timeout_clr_i = clr;
    rst_i         = rst;
    if (ack) ack_q.push_back((m_busy && !rst) ? (N'(1) << m_gnt) : '0);
    if (rst) begin
      m_valid   = 1'b1;
      m_busy    = 1'b0;
      m_gnt     = 0;
      m_ptr     = 0;
      m_elapsed = 0;
      m_to      = 1'b0;
    end else begin
      m_to = (m_busy && m_elapsed >= TO) || (m_to && !clr);
      if (m_busy) begin
        if (ack) begin
          m_busy = 1'b0;
          m_ptr  = (m_gnt + 1) % N;
        end else begin
          m_elapsed++;
        end
      end else begin
        w = pick(req, m_ptr);
        if (w >= 0) begin
          m_busy    = 1'b1;
          m_gnt     = w;
          m_elapsed = 0;
        end
      end
    end
  endtask

  // Monitor: checks registered outputs every cycle and every ACK pulse
  // against the queued predictions.
  always @(negedge clk) begin
    cyc_exp_t e;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      checkOutput("out_req", 32'(out_req_o), 32'(e.req));
      checkOutput("busy", 32'(busy_o), 32'(e.req));
      checkOutput("timeout", 32'(timeout_o), 32'(e.to));
      checkOutput("gnt_idx", 32'(gnt_idx_o), 32'(e.gnt));
    end
    if (out_ack_i === 1'b1 || (ack_o !== 'x && ack_o != '0)) begin
      if (ack_q.size() == 0) checkOutput("ack_unexpected", 32'(ack_o), 32'(0));
      else checkOutput("ack", 32'(ack_o), 32'(ack_q.pop_front()));
    end
  end

  initial begin
    logic [N-1:0] req_cur;
    int           last_ack;
    int           age;
    int           ack_delay;
    bit           was_busy;
    logic         ack;
    logic         clr;
    logic         rst;

    rst_i         = 1'b1;
    req_i         = '0;
    out_ack_i     = 1'b0;
    timeout_clr_i = 1'b0;

    repeat (3) applyStimulus('0, 1'b0, 1'b0, 1'b1);

    // Single requester 2: grant one cycle after the request, ACK routed
    // to bit 2 in the ACK cycle, REQ drops the cycle after.
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    // Pointer now at 3: requesters 0,1 win in order; bit 3 raised mid-grant waits.
    applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1011, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1011, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b1010, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1010, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    // All requesters held, fastest ACK: order 0,1,2,3,0 with pointer wrap.
    repeat (2) applyStimulus('0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(4'b1111, m_busy, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    // Withheld ACK trips the watchdog; a clear coinciding with set loses,
    // the late ACK still completes, and a later clear drops the flag.
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) applyStimulus(4'b0001, 1'b0, k == 10, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    // Reset mid-grant discards it; a stray ACK while resetting gives no ack_o.
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    // Random traffic: requesters rise at will, hold until ACKed, and may
    // re-request; ACK latency is random and sometimes exceeds the watchdog.
    req_cur   = '0;
    last_ack  = -1;
    age       = 0;
    ack_delay = 0;
    for (int c = 0; c < 3000; c++) begin
      if (last_ack >= 0 && $urandom_range(1, 0) == 1) req_cur &= ~(N'(1) << last_ack);
      last_ack = -1;
      for (int i = 0; i < N; i++) begin
        if (!bitOf(req_cur, i) && $urandom_range(2, 0) == 0) req_cur |= N'(1) << i;
      end
      rst = ($urandom_range(399, 0) == 0);
      clr = ($urandom_range(15, 0) == 0);
      ack = 1'b0;
      if (m_busy && !rst) begin
        if (age >= ack_delay) begin
          ack      = 1'b1;
          last_ack = m_gnt;
        end else begin
          age++;
        end
      end
      was_busy = m_busy;
      applyStimulus(req_cur, ack, clr, rst);
      if (rst) applyStimulus(req_cur, $urandom_range(1, 0) == 1, 1'b0, 1'b1);
      if (!was_busy && m_busy) begin
        age       = 0;
        ack_delay = $urandom_range(13, 0);
      end
    end

    @(negedge clk);
    @(negedge clk);
    checkOutput("cyc_q_drained", 32'(cyc_q.size()), 32'(0));
    checkOutput("ack_q_drained", 32'(ack_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
